// File: rtl/add_pkg.sv
// Shared types and defaults for the pair accumulator and its ripple adder.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned N_DEF     = 6;
    localparam int unsigned ACC_W_DEF = 12;

endpackage

// File: rtl/ripple.sv
// N-bit ripple-carry adder: s = a + b, c = carry out of the top bit.
module ripple #(
    parameter int unsigned N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         c
);

    logic [N:0] carry;

    assign carry[0] = 1'b0;

    // One full adder per bit, carry chained from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c = carry[N];

endmodule

// File: rtl/add_accum.sv
// Sums the {c,s} values of LEN operand pairs and hands the total downstream
// over a valid/ready handshake with a sticky wrap flag.
module add_accum
    import add_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned LEN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(LEN + 1);

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               ovf_next;
    logic               out_valid_next;
    logic [ACC_W-1:0]   result_next;

    logic [N-1:0]       pair_s;
    logic               pair_c;
    logic [ACC_W-1:0]   pv;
    logic [ACC_W:0]     sum;
    logic               xfer;
    logic               last;

    ripple #(.N(N)) u_ripple (
        .a (a),
        .b (b),
        .s (pair_s),
        .c (pair_c)
    );

    assign pv   = ACC_W'({pair_c, pair_s});
    assign sum  = {1'b0, acc} + (ACC_W + 1)'(pv);
    assign xfer = in_valid && (state == ACC);
    assign last = (count == CNT_W'(LEN - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            count     <= count_next;
            ovf       <= ovf_next;
            out_valid <= out_valid_next;
            result    <= result_next;
            in_ready  <= (state_next == ACC);
        end
    end

    // Next-state decode; clear forces a fresh accumulation from any state.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ACC;
        end else begin
            case (state)
                IDLE:    state_next = ACC;
                ACC:     if (xfer && last) state_next = HOLD;
                HOLD:    if (out_ready) state_next = ACC;
                default: state_next = IDLE;
            endcase
        end
    end

    // Accumulator, pair counter and result update.
    always_comb begin
        acc_next       = acc;
        count_next     = count;
        ovf_next       = ovf;
        out_valid_next = out_valid;
        result_next    = result;
        if (clear) begin
            acc_next       = '0;
            count_next     = '0;
            ovf_next       = 1'b0;
            out_valid_next = 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (xfer) begin
                        acc_next = sum[ACC_W-1:0];
                        ovf_next = ovf | sum[ACC_W];
                        if (last) begin
                            count_next     = '0;
                            result_next    = sum[ACC_W-1:0];
                            out_valid_next = 1'b1;
                        end else begin
                            count_next = count + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_next = 1'b0;
                        acc_next       = '0;
                        ovf_next       = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_accum.sv
// Bench for add_accum: two widths (12- and 8-bit accumulator) driven in lockstep
// and checked against an integer running-total model.
module tb_add_accum;

    localparam int unsigned N   = 6;
    localparam int unsigned LEN = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;

    logic         in_ready_a, out_valid_a, ovf_a;
    logic [11:0]  result_a;
    logic         in_ready_b, out_valid_b, ovf_b;
    logic [7:0]   result_b;

    int n_assert = 0;
    int fails = 0;
    int total = 0;
    int cnt = 0;

    always #5 clk = ~clk;

    add_accum #(.N(N), .ACC_W(12), .LEN(LEN)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a), .a(a), .b(b),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .result(result_a), .ovf(ovf_a)
    );

    add_accum #(.N(N), .ACC_W(8), .LEN(LEN)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b), .a(a), .b(b),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .result(result_b), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 16'(in_ready_a), 16'(0));
        chk({tag, "_out_valid"}, 16'(out_valid_a), 16'(0));
        chk({tag, "_result"}, 16'(result_a), 16'(0));
        chk({tag, "_ovf"}, 16'(ovf_a), 16'(0));
        chk({tag, "_result8"}, 16'(result_b), 16'(0));
        chk({tag, "_ovf8"}, 16'(ovf_b), 16'(0));
    endtask

    // Expected result is the plain integer total reduced modulo each width.
    task automatic chk_result(input string tag);
        chk({tag, "_out_valid"}, 16'(out_valid_a), 16'(1));
        chk({tag, "_out_valid8"}, 16'(out_valid_b), 16'(1));
        chk({tag, "_result12"}, 16'(result_a), 16'(total % 4096));
        chk({tag, "_ovf12"}, 16'(ovf_a), 16'(total >= 4096));
        chk({tag, "_result8"}, 16'(result_b), 16'(total % 256));
        chk({tag, "_ovf8"}, 16'(ovf_b), 16'(total >= 256));
    endtask

    task automatic send_pair(input int av, input int bv);
        a = N'(av);
        b = N'(bv);
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !in_ready_a; k++) tick();
        chk("in_ready_wait", 16'(in_ready_a), 16'(1));
        tick();
        in_valid = 1'b0;
        total += av + bv;
        cnt++;
        if (cnt == LEN) chk_result("run");
        else chk("mid_run_out_valid", 16'(out_valid_a), 16'(0));
    endtask

    task automatic handshake(input int stall);
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            a = N'($urandom);
            b = N'($urandom);
            tick();
            chk("hold_in_ready", 16'(in_ready_a), 16'(0));
            chk_result("hold");
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_out_valid", 16'(out_valid_a), 16'(0));
        chk("post_hs_in_ready", 16'(in_ready_a), 16'(1));
        total = 0;
        cnt = 0;
    endtask

    task automatic run_const(input int av, input int bv, input int gap);
        for (int p = 0; p < LEN; p++) begin
            send_pair(av, bv);
            if (p < LEN - 1) repeat (gap) tick();
        end
    endtask

    initial begin
        // Reset release
        #1;
        chk_idle_outputs("reset");
        repeat (3) tick();
        chk_idle_outputs("reset_hold");
        rst_n = 1'b1;
        chk("rel_cycle1_in_ready", 16'(in_ready_a), 16'(0));
        tick();
        chk("rel_cycle2_in_ready", 16'(in_ready_a), 16'(1));
        chk("rel_cycle2_out_valid", 16'(out_valid_a), 16'(0));
        chk("rel_cycle2_result", 16'(result_a), 16'(0));

        // Basic run: 12 + 15 + 126 + 2 = 155
        send_pair(5, 7);
        send_pair(0, 15);
        send_pair(63, 63);
        send_pair(1, 1);
        chk("basic_155", 16'(result_a), 16'(155));

        // Backpressure, then a fresh run of 4x(5,7) = 48
        handshake(3);
        run_const(5, 7, 0);
        chk("bp_next_48", 16'(result_a), 16'(48));
        handshake(0);

        // Overflow: 4x(63,63) = 504, wraps the 8-bit accumulator
        run_const(63, 63, 0);
        chk("ovf_res8", 16'(result_b), 16'(248));
        chk("ovf_flag8", 16'(ovf_b), 16'(1));
        handshake(1);
        run_const(1, 1, 0);
        chk("ovf_after_res8", 16'(result_b), 16'(8));
        chk("ovf_after_flag8", 16'(ovf_b), 16'(0));
        handshake(0);

        // Clear with a simultaneous transfer drops the pair
        send_pair(5, 7);
        send_pair(5, 7);
        a = N'(9);
        b = N'(9);
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        total = 0;
        cnt = 0;
        chk("clear_in_ready", 16'(in_ready_a), 16'(1));
        chk("clear_out_valid", 16'(out_valid_a), 16'(0));
        run_const(5, 7, 0);
        chk("clear_next_48", 16'(result_a), 16'(48));

        // Clear while a result is pending discards it
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total = 0;
        cnt = 0;
        chk("clear_hold_out_valid", 16'(out_valid_a), 16'(0));
        chk("clear_hold_in_ready", 16'(in_ready_a), 16'(1));

        // Bubbles between pairs
        run_const(5, 7, 2);
        chk("bubble_48", 16'(result_a), 16'(48));
        handshake(0);

        // Mid-run reset discards partial state, including a set wrap flag
        send_pair(63, 63);
        send_pair(63, 63);
        send_pair(63, 63);
        chk("midrun_ovf8_set", 16'(ovf_b), 16'(1));
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrun_reset");
        tick();
        rst_n = 1'b1;
        total = 0;
        cnt = 0;
        run_const(5, 7, 0);
        chk("after_reset_48", 16'(result_a), 16'(48));
        chk("after_reset_ovf8", 16'(ovf_b), 16'(0));
        handshake(0);

        // Randomized runs with random bubbles and stalls
        for (int r = 0; r < 15; r++) begin
            for (int p = 0; p < LEN; p++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_pair(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            end
            handshake(int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fails);
        $finish;
    end

endmodule
